// File: rtl/heap_memory_pkg.sv
// Lisp tagged-word definitions shared by the heap and its clients.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Word layout (MSB..LSB): mark bit | TYPE_W type tag | ADDR_W pointer field.
package lisp_defs;

    localparam int TYPE_W      = 3;
    localparam int LISP_ADDR_W = 12;
    localparam int LISP_WORD_W = 1 + TYPE_W + LISP_ADDR_W;

    localparam logic [TYPE_W-1:0] TYPE_NUM  = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_CONS = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_SYM  = 3'd2;

    // NIL is the symbol living at address 0 of the ROM area.
    localparam logic [LISP_WORD_W-1:0] LISP_NIL = {1'b0, TYPE_SYM, 12'd0};

    typedef enum logic [0:0] {
        ConsIdle,
        ConsWriteCar
    } cons_state_t;

    function automatic logic [TYPE_W-1:0] word_type(input logic [LISP_WORD_W-1:0] w);
        return w[LISP_WORD_W-2 -: TYPE_W];
    endfunction

    function automatic logic [LISP_ADDR_W-1:0] word_ptr(input logic [LISP_WORD_W-1:0] w);
        return w[LISP_ADDR_W-1:0];
    endfunction

    function automatic logic [LISP_WORD_W-1:0] make_word(input logic [TYPE_W-1:0] t,
                                                         input logic [LISP_ADDR_W-1:0] p);
        return {1'b0, t, p};
    endfunction

endpackage

// File: rtl/heap_memory_if.sv
// Bus bundle between heap clients (master) and heap_memory (slave).
// Latency: none (wires only).
// Backpressure: reads via rd_req/rd_gnt, conses via cons_valid/cons_ready.
//
// Ports: rd_req/rd_addr/rd_gnt/rd_valid/rd_data per read channel,
// cons_valid/cons_car/cons_cdr/cons_ready/cons_done/cons_ptr/cons_oom for
// allocation, heap_clear and free_cells for allocator management.
interface heap_memory_if #(
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 12,
    parameter int WORD_W = 16
);
    logic [NUM_RD-1:0]             rd_req;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]             rd_gnt;
    logic [NUM_RD-1:0]             rd_valid;
    logic [NUM_RD-1:0][WORD_W-1:0] rd_data;

    logic              cons_valid;
    logic [WORD_W-1:0] cons_car;
    logic [WORD_W-1:0] cons_cdr;
    logic              cons_ready;
    logic              cons_done;
    logic [WORD_W-1:0] cons_ptr;
    logic              cons_oom;

    logic              heap_clear;
    logic [ADDR_W:0]   free_cells;

    modport master (
        output rd_req, rd_addr, cons_valid, cons_car, cons_cdr, heap_clear,
        input  rd_gnt, rd_valid, rd_data, cons_ready, cons_done, cons_ptr,
               cons_oom, free_cells
    );

    modport slave (
        input  rd_req, rd_addr, cons_valid, cons_car, cons_cdr, heap_clear,
        output rd_gnt, rd_valid, rd_data, cons_ready, cons_done, cons_ptr,
               cons_oom, free_cells
    );
endinterface

// File: rtl/heap_memory_ram.sv
// Simple dual-port block RAM, one write and one read port, read-first.
// Latency: 1 cycle read (rdata registered), write lands on the same edge.
// Backpressure: none; accepts a read and a write every cycle.
//
// Ports: clk, we/waddr/wdata write port, re/raddr/rdata read port.
// Contents: word 0 = INIT_WORD0 and the rest zero.
module heap_ram #(
    parameter int              WORD_W     = 16,
    parameter int              RA_W       = 8,
    parameter int              DEPTH      = 256,
    parameter                  INIT_FILE  = "",
    parameter logic [WORD_W-1:0] INIT_WORD0 = '0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [RA_W-1:0]   raddr,
    output logic [WORD_W-1:0] rdata
);

    (* ram_style = "block" *) logic [WORD_W-1:0] mem [DEPTH];

    // Power-on image only; the array itself is never reset.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[0] = INIT_WORD0;
    end

    // Non-blocking read of the array gives the old word on a same-address
    // collision (read-first).
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/heap_memory.sv
// Lisp heap: NUM_RD round-robin read channels plus a bump cons allocator.
// Latency: read data 1 cycle after grant; cons_done 2 cycles after accept.
// Backpressure: rd_gnt selects one requester per cycle; cons_ready drops while
// writing CAR, when fewer than 2 words remain, or during heap_clear.
//
// Ports: clk, rst (async, active-high), bus (heap_memory_if.slave).
module heap_memory
    import lisp_defs::*;
#(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 256,
    parameter int HEAP_START = 5,
    parameter int NUM_RD     = 2,
    parameter     INIT_FILE  = ""
) (
    input logic          clk,
    input logic          rst,
    heap_memory_if.slave bus
);

    localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int RA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WORD_W-1:0] NIL_WORD  = {1'b0, TYPE_SYM, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   START_W   = (ADDR_W+1)'(HEAP_START);
    localparam logic [IDX_W-1:0]  RR_INIT   = IDX_W'(NUM_RD - 1);

    // ---------------- read arbiter ----------------
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [NUM_RD-1:0] gnt;
    logic              gnt_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oor;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int c;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        c       = 0;
        for (int i = 1; i <= NUM_RD; i++) begin
            c = (int'(rr_ptr) + i) % NUM_RD;
            if (!gnt_any && bus.rd_req[c]) begin
                gnt_any = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

    assign bus.rd_gnt = rst ? '0 : gnt;
    assign sel_addr   = bus.rd_addr[gnt_idx];
    assign sel_oor    = ({1'b0, sel_addr} >= DEPTH_W);

    // ---------------- cons allocator ----------------
    cons_state_t       state;
    logic [ADDR_W:0]   heap_ptr;
    logic [WORD_W-1:0] car_q;
    logic [ADDR_W:0]   free_cells;
    logic              cons_ready;
    logic              cons_accept;
    logic              ram_we;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_q;

    assign free_cells  = DEPTH_W - heap_ptr;
    assign cons_ready  = (state == ConsIdle) && (free_cells >= (ADDR_W+1)'(2)) && !bus.heap_clear;
    assign cons_accept = bus.cons_valid && cons_ready;

    // CDR goes out straight from the request; CAR is captured at accept so the
    // caller may move on to its next cell immediately.
    assign ram_we    = cons_accept || (state == ConsWriteCar);
    assign ram_wdata = (state == ConsWriteCar) ? car_q : bus.cons_cdr;

    assign bus.free_cells = free_cells;
    assign bus.cons_ready = cons_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ConsIdle;
            heap_ptr      <= START_W;
            car_q         <= '0;
            bus.cons_done <= 1'b0;
            bus.cons_ptr  <= '0;
            bus.cons_oom  <= 1'b0;
        end else begin
            bus.cons_done <= 1'b0;
            case (state)
                ConsIdle: begin
                    if (bus.heap_clear) begin
                        heap_ptr     <= START_W;
                        bus.cons_oom <= 1'b0;
                    end else if (cons_accept) begin
                        car_q    <= bus.cons_car;
                        heap_ptr <= heap_ptr + 1'b1;
                        state    <= ConsWriteCar;
                    end else if (bus.cons_valid) begin
                        // Not ready in Idle without a clear means < 2 words left.
                        bus.cons_oom <= 1'b1;
                    end
                end
                ConsWriteCar: begin
                    bus.cons_ptr  <= {1'b0, TYPE_CONS, heap_ptr[ADDR_W-1:0]};
                    bus.cons_done <= 1'b1;
                    heap_ptr      <= heap_ptr + 1'b1;
                    state         <= ConsIdle;
                end
                default: state <= ConsIdle;
            endcase
        end
    end

    // ---------------- RAM and read return ----------------
    heap_ram #(
        .WORD_W    (WORD_W),
        .RA_W      (RA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE),
        .INIT_WORD0(NIL_WORD)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(heap_ptr[RA_W-1:0]),
        .wdata(ram_wdata),
        .re   (gnt_any && !sel_oor),
        .raddr(sel_addr[RA_W-1:0]),
        .rdata(ram_q)
    );

    logic [NUM_RD-1:0]             vld_q;
    logic                          oor_q;
    logic [NUM_RD-1:0][WORD_W-1:0] hold_q;
    logic [WORD_W-1:0]             rd_word;

    assign rd_word      = oor_q ? NIL_WORD : ram_q;
    assign bus.rd_valid = vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= RR_INIT;
            vld_q  <= '0;
            oor_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            vld_q <= gnt;
            oor_q <= sel_oor;
            if (gnt_any) rr_ptr <= gnt_idx;
            for (int ch = 0; ch < NUM_RD; ch++) begin
                if (vld_q[ch]) hold_q[ch] <= rd_word;
            end
        end
    end

    // The shared RAM output register serves whichever channel was granted;
    // each channel keeps its last word afterwards.
    always_comb begin
        for (int ch = 0; ch < NUM_RD; ch++) begin
            bus.rd_data[ch] = vld_q[ch] ? rd_word : hold_q[ch];
        end
    end

endmodule

// File: tb/tb_heap_memory.sv
// Self-checking bench for heap_memory (default heap plus a 16-word heap).
// Latency: not applicable.
// Backpressure: not applicable.
module tb_heap_memory;

    localparam logic [15:0] NIL  = 16'h2000;
    localparam logic [15:0] CONS = 16'h1000;

    logic clk;
    logic rst;

    heap_memory_if #(.NUM_RD(2), .ADDR_W(12), .WORD_W(16)) a_if ();
    heap_memory_if #(.NUM_RD(2), .ADDR_W(12), .WORD_W(16)) b_if ();

    heap_memory #(.WORD_W(16), .ADDR_W(12), .DEPTH(256), .HEAP_START(5),
                  .NUM_RD(2), .INIT_FILE("")) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));

    heap_memory #(.WORD_W(16), .ADDR_W(12), .DEPTH(16), .HEAP_START(5),
                  .NUM_RD(2), .INIT_FILE("")) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mdl [256];
    int          exp_hp;
    logic [15:0] exp_q [2][$];
    logic [15:0] cons_q [$];

    function automatic logic [15:0] mdl_read(input logic [11:0] addr);
        if (addr >= 12'd256) return NIL;
        return mdl[addr[7:0]];
    endfunction

    // Round-robin prediction, grant/valid checks and read scoreboard (dut_a).
    int         m_last;
    logic [1:0] m_prev;
    logic [1:0] m_gnt;
    always @(negedge clk) begin
        if (rst) begin
            m_last = 1;
            m_prev = 2'b00;
            check("rd_gnt_rst", a_if.rd_gnt, 2'b00);
            check("rd_valid_rst", a_if.rd_valid, 2'b00);
        end else begin
            m_gnt = 2'b00;
            for (int k = 1; k <= 2; k++) begin
                if (m_gnt == 2'b00 && a_if.rd_req[(m_last + k) % 2])
                    m_gnt[(m_last + k) % 2] = 1'b1;
            end
            check("rd_gnt", a_if.rd_gnt, m_gnt);
            check("rd_valid", a_if.rd_valid, m_prev);
            for (int ch = 0; ch < 2; ch++) begin
                if (a_if.rd_valid[ch]) begin
                    if (exp_q[ch].size() == 0) check("rd_spurious", 1, 0);
                    else check("rd_data", a_if.rd_data[ch], exp_q[ch].pop_front());
                end
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (m_gnt[ch]) begin
                    exp_q[ch].push_back(mdl_read(a_if.rd_addr[ch]));
                    m_last = ch;
                end
            end
            m_prev = m_gnt;
        end
    end

    // Cons completion scoreboard (dut_a).
    always @(negedge clk) begin
        if (a_if.cons_done) begin
            if (cons_q.size() == 0) check("cons_spurious", 1, 0);
            else check("cons_ptr", a_if.cons_ptr, cons_q.pop_front());
        end
    end

    // dut_b allocates strictly sequentially from address 5.
    int b_done_cnt = 0;
    always @(negedge clk) begin
        if (b_if.cons_done) begin
            check("b_cons_ptr", b_if.cons_ptr, 32'(CONS) + 32'(6 + 2 * b_done_cnt));
            b_done_cnt++;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cons_done", a_if.cons_done, 0);
        check("rst_cons_ptr", a_if.cons_ptr, 0);
        check("rst_cons_oom", a_if.cons_oom, 0);
        check("rst_free", a_if.free_cells, 251);
        check("rst_rd_data", a_if.rd_data[0], 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_hp = 5;
    endtask

    task automatic rd_a(input int ch, input logic [11:0] addr);
        @(posedge clk); #1;
        a_if.rd_req[ch]  = 1'b1;
        a_if.rd_addr[ch] = addr;
        @(posedge clk); #1;
        a_if.rd_req[ch] = 1'b0;
        @(negedge clk);
    endtask

    task automatic cons_a(input logic [15:0] car, input logic [15:0] cdr);
        int n;
        n = 0;
        @(posedge clk); #1;
        a_if.cons_valid = 1'b1;
        a_if.cons_car   = car;
        a_if.cons_cdr   = cdr;
        @(negedge clk);
        while (!a_if.cons_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.cons_ready) begin
            check("cons_accept_timeout", 0, 1);
            a_if.cons_valid = 1'b0;
        end else begin
            cons_q.push_back(CONS | 16'(exp_hp + 1));
            @(posedge clk); #1;
            a_if.cons_valid = 1'b0;
            mdl[exp_hp] = cdr;
            @(negedge clk);
            check("cons_done_n1", a_if.cons_done, 0);
            @(posedge clk); #1;
            mdl[exp_hp + 1] = car;
            exp_hp += 2;
            @(negedge clk);
            check("cons_done_n2", a_if.cons_done, 1);
            check("free_after_cons", a_if.free_cells, 256 - exp_hp);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        rst = 1'b1;
        a_if.rd_req = '0;  a_if.rd_addr = '0;  a_if.cons_valid = 1'b0;
        a_if.cons_car = '0; a_if.cons_cdr = '0; a_if.heap_clear = 1'b0;
        b_if.rd_req = '0;  b_if.rd_addr = '0;  b_if.cons_valid = 1'b0;
        b_if.cons_car = '0; b_if.cons_cdr = '0; b_if.heap_clear = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
        mdl[0] = NIL;
        exp_hp = 5;

        do_reset();
        // Single read of NIL on channel 0.
        rd_a(0, 12'd0);
        check("rd0_hold", a_if.rd_data[0], NIL);

        // Two channels contending for four cycles: 0,1,0,1.
        do_reset();
        @(posedge clk); #1;
        a_if.rd_addr[0] = 12'd1;
        a_if.rd_addr[1] = 12'd2;
        a_if.rd_req     = 2'b11;
        repeat (4) @(posedge clk);
        #1 a_if.rd_req = 2'b00;
        @(negedge clk);

        // First cons after reset, then read the cell back.
        do_reset();
        cons_a(16'hDEAD, 16'hBEEF);
        check("free_249", a_if.free_cells, 249);
        rd_a(0, 12'd5);
        rd_a(1, 12'd6);
        rd_a(0, 12'd300);
        rd_a(1, 12'd255);

        // Read of the CDR address while it is being written, then re-read.
        fork
            cons_a(16'h1234, 16'h5678);
            begin
                @(posedge clk); #1;
                a_if.rd_req[0]  = 1'b1;
                a_if.rd_addr[0] = 12'd7;
                @(posedge clk); #1;
                @(posedge clk); #1;
                a_if.rd_req[0] = 1'b0;
            end
        join
        rd_a(1, 12'd8);

        // Reset while the CAR write is pending.
        @(posedge clk); #1;
        a_if.cons_valid = 1'b1;
        a_if.cons_car   = 16'hAAAA;
        a_if.cons_cdr   = 16'h5555;
        @(negedge clk);
        check("mid_ready", a_if.cons_ready, 1);
        @(posedge clk); #1;
        a_if.cons_valid = 1'b0;
        mdl[exp_hp] = 16'h5555;
        rst = 1'b1;
        #1;
        check("mid_done", a_if.cons_done, 0);
        check("mid_ptr", a_if.cons_ptr, 0);
        check("mid_oom", a_if.cons_oom, 0);
        check("mid_free", a_if.free_cells, 251);
        check("mid_gnt", a_if.rd_gnt, 0);
        @(negedge clk);
        check("mid_done_hold", a_if.cons_done, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_hp = 5;
        cons_a(16'h0C0C, 16'h0B0B);
        rd_a(0, 12'd5);
        rd_a(1, 12'd6);

        // 16-word heap: exhaust, overflow, clear.
        @(posedge clk); #1;
        b_if.cons_valid = 1'b1;
        b_if.cons_car   = 16'h00A0;
        b_if.cons_cdr   = 16'h00D0;
        acc = 0;
        for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
            @(negedge clk);
            if (b_if.cons_valid && b_if.cons_ready) acc++;
            @(posedge clk); #1;
            b_if.cons_car = 16'h00A0 + 16'(acc);
            b_if.cons_cdr = 16'h00D0 + 16'(acc);
            if (acc == 5) b_if.cons_valid = 1'b0;
        end
        b_if.cons_valid = 1'b0;
        check("b_accepts", acc, 5);
        repeat (3) @(negedge clk);
        check("b_done_cnt", b_done_cnt, 5);
        check("b_free_1", b_if.free_cells, 1);
        check("b_ready_0", b_if.cons_ready, 0);
        check("b_oom_0", b_if.cons_oom, 0);
        @(posedge clk); #1;
        b_if.cons_valid = 1'b1;
        @(posedge clk); #1;
        b_if.cons_valid = 1'b0;
        @(negedge clk);
        check("b_oom_1", b_if.cons_oom, 1);
        check("b_free_still_1", b_if.free_cells, 1);
        check("b_no_done", b_done_cnt, 5);
        @(posedge clk); #1;
        b_if.heap_clear = 1'b1;
        @(negedge clk);
        check("b_ready_in_clear", b_if.cons_ready, 0);
        @(posedge clk); #1;
        b_if.heap_clear = 1'b0;
        @(negedge clk);
        check("b_free_11", b_if.free_cells, 11);
        check("b_oom_cleared", b_if.cons_oom, 0);
        check("b_ready_1", b_if.cons_ready, 1);

        repeat (2) @(negedge clk);
        check("rd_q0_empty", exp_q[0].size(), 0);
        check("rd_q1_empty", exp_q[1].size(), 0);
        check("cons_q_empty", cons_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
